// File: rtl/sched_pkg.sv
// sched_pkg: shared scheduler types, fire-bus width helper and idle-code convention
package sched_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        QUIET
    } state_e;

    // Width of a bus that can carry every index 0..n-1 plus the idle code n
    function automatic int fire_w(input int n);
        return $clog2(n + 1);
    endfunction

    // The idle code on a fire bus is always the signal count itself
    function automatic int idle_code(input int n);
        return n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin grant, first set request at or after ptr, wrapping at N
module rr_pick #(
    parameter int N  = 8,
    parameter int FW = $clog2(N + 1)
) (
    input  logic [N-1:0]  req_i,
    input  logic [FW-1:0] ptr_i,
    output logic [FW-1:0] grant_idx_o,
    output logic          any_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest request after ptr wins
    always_comb begin
        grant_idx_o = FW'(N);
        idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (req_i[idx]) grant_idx_o = FW'(idx);
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fire_scheduler.sv
// fire_scheduler: bounded fair selection of one excited signal per cycle, with quiescence and starvation flags
module fire_scheduler
    import sched_pkg::*;
#(
    parameter int N             = 8,
    parameter int FW            = fire_w(N),
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_WAIT      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  excited_i,
    input  logic          det_i,
    input  logic [FW-1:0] pick_i,
    output logic [FW-1:0] fire_o,
    output logic          fire_valid_o,
    output logic          stable_o,
    output logic          starved_o,
    output logic [FW-1:0] starved_idx_o
);

    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [FW-1:0] IDLE = FW'(idle_code(N));

    state_e        state_q, state_d;
    logic [FW-1:0] fire_q, fire_d;
    logic [FW-1:0] rr_q, rr_d;
    logic [FW-1:0] starved_idx_q, starved_idx_d;
    logic [FW-1:0] grant;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [WW-1:0] wait_q [N];
    logic [WW-1:0] wait_d [N];
    logic          starved_q, starved_d;
    logic          any_exc, pick_ok;

    rr_pick #(.N(N), .FW(FW)) u_rr_pick (
        .req_i       (excited_i),
        .ptr_i       (rr_q),
        .grant_idx_o (grant),
        .any_o       (any_exc)
    );

    // An out-of-range pick shifts the mask out entirely, so it can never be honoured
    assign pick_ok = !det_i && |(excited_i & (N'(1) << pick_i));

    // FSM, selection and quiet counter; QUIET exits straight into a selection
    always_comb begin
        state_d = state_q;
        fire_d  = IDLE;
        rr_d    = rr_q;
        quiet_d = any_exc ? '0 : (quiet_q == QW'(STABLE_CYCLES)) ? quiet_q : quiet_q + 1'b1;
        case (state_q)
            HOLD:    state_d = RUN;
            RUN:     state_d = (!any_exc && quiet_q >= QW'(STABLE_CYCLES - 1)) ? QUIET : RUN;
            QUIET:   state_d = any_exc ? RUN : QUIET;
            default: state_d = HOLD;
        endcase
        if (state_q != HOLD && any_exc) begin
            fire_d = pick_ok ? pick_i : grant;
            if (!pick_ok) rr_d = (grant == FW'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Per-signal wait counters; descending scan lets the lowest starving index win
    always_comb begin
        wait_d        = wait_q;
        starved_d     = starved_q;
        starved_idx_d = starved_idx_q;
        for (int i = N - 1; i >= 0; i--) begin
            wait_d[i] = (excited_i[i] && fire_q != FW'(i))
                      ? ((wait_q[i] == WW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + 1'b1)
                      : '0;
            if (!starved_q && wait_d[i] == WW'(MAX_WAIT)) begin
                starved_d     = 1'b1;
                starved_idx_d = FW'(i);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HOLD;
            fire_q        <= IDLE;
            rr_q          <= '0;
            quiet_q       <= '0;
            starved_q     <= 1'b0;
            starved_idx_q <= '0;
            for (int i = 0; i < N; i++) wait_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            fire_q        <= fire_d;
            rr_q          <= rr_d;
            quiet_q       <= quiet_d;
            starved_q     <= starved_d;
            starved_idx_q <= starved_idx_d;
            for (int i = 0; i < N; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign fire_o        = fire_q;
    assign fire_valid_o  = fire_q < IDLE;
    assign stable_o      = state_q == QUIET;
    assign starved_o     = starved_q;
    assign starved_idx_o = starved_idx_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// tb_fire_scheduler: randomized and directed scoreboard bench against a behavioural scheduler model
module tb_fire_scheduler;

    localparam int N  = 4;
    localparam int FW = 3;
    localparam int SC = 4;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  excited_i = '0;
    logic          det_i = 1'b1;
    logic [FW-1:0] pick_i = '0;
    logic [FW-1:0] fire_o;
    logic          fire_valid_o;
    logic          stable_o;
    logic          starved_o;
    logic [FW-1:0] starved_idx_o;

    fire_scheduler #(.N(N), .FW(FW), .STABLE_CYCLES(SC), .MAX_WAIT(MW)) dut (
        .clk           (clk),
        .reset         (reset),
        .excited_i     (excited_i),
        .det_i         (det_i),
        .pick_i        (pick_i),
        .fire_o        (fire_o),
        .fire_valid_o  (fire_valid_o),
        .stable_o      (stable_o),
        .starved_o     (starved_o),
        .starved_idx_o (starved_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0] fire;
        logic          valid;
        logic          stable;
        logic          starved;
        logic [FW-1:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t want, got;
    int   tests = 0;
    int   fails = 0;

    // Behavioural model: signals since reset, consecutive idle cycles, per-signal waiting time
    int m_fire, m_rr, m_idle, m_sidx;
    int m_wait[N];
    bit m_hold, m_starved, m_stable;

    function automatic void model_reset();
        m_fire = N; m_rr = 0; m_idle = 0; m_hold = 1'b1;
        m_starved = 1'b0; m_sidx = 0; m_stable = 1'b0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endfunction

    function automatic void model_step(input logic [N-1:0] e, input logic d, input int p);
        int nf;
        bit found;
        for (int i = 0; i < N; i++)
            m_wait[i] = (e[i] && m_fire != i) ? ((m_wait[i] < MW) ? m_wait[i] + 1 : MW) : 0;
        found = 1'b0;
        if (!m_starved)
            for (int i = 0; i < N; i++)
                if (!found && m_wait[i] == MW) begin
                    found = 1'b1; m_starved = 1'b1; m_sidx = i;
                end
        m_idle = (e == '0) ? m_idle + 1 : 0;
        nf = N;
        if (!m_hold && e != '0) begin
            if (!d && p < N && e[p]) nf = p;
            else begin
                found = 1'b0;
                for (int k = 0; k < N; k++)
                    if (!found && e[(m_rr + k) % N]) begin
                        found = 1'b1; nf = (m_rr + k) % N;
                    end
                m_rr = (nf + 1) % N;
            end
        end
        m_stable = !m_hold && m_idle >= SC;
        m_hold = 1'b0;
        m_fire = nf;
    endfunction

    task automatic apply(input logic [N-1:0] e, input logic d, input logic [FW-1:0] p);
        exp_t x;
        excited_i = e; det_i = d; pick_i = p;
        model_step(e, d, int'(p));
        x = {FW'(m_fire), m_fire < N, m_stable, m_starved, FW'(m_sidx)};
        q.push_back(x);
    endtask

    task automatic step(input logic [N-1:0] e, input logic d, input logic [FW-1:0] p);
        @(negedge clk); #1;
        apply(e, d, p);
    endtask

    task automatic check_reset(input string tag);
        tests++;
        if (fire_o !== FW'(N) || fire_valid_o !== 1'b0 || stable_o !== 1'b0 ||
            starved_o !== 1'b0 || starved_idx_o !== '0) begin
            fails++;
            $display("FAIL %s: fire=%0d valid=%b stable=%b starved=%b idx=%0d, want fire=%0d valid=0 stable=0 starved=0 idx=0",
                     tag, fire_o, fire_valid_o, stable_o, starved_o, starved_idx_o, N);
        end
    endtask

    // Reset asserted mid-cycle so only the asynchronous path can clear the outputs
    task automatic do_reset(input logic [N-1:0] e, input logic d, input logic [FW-1:0] p);
        @(negedge clk); #3;
        reset = 1'b0;
        #1;
        check_reset("async_reset");
        q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("reset_held");
        #1;
        reset = 1'b1;
        apply(e, d, p);
    endtask

    // Monitor: each cycle the DUT presents a registered decision, compare with the oldest expectation
    always @(negedge clk) begin
        if (reset && q.size() > 0) begin
            want = q.pop_front();
            got  = {fire_o, fire_valid_o, stable_o, starved_o, starved_idx_o};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL cycle_out @%0t: fire=%0d valid=%b stable=%b starved=%b idx=%0d, expected fire=%0d valid=%b stable=%b starved=%b idx=%0d",
                         $time, got.fire, got.valid, got.stable, got.starved, got.idx,
                         want.fire, want.valid, want.stable, want.starved, want.idx);
            end
        end
    end

    initial begin
        logic [N-1:0] e;
        logic [FW-1:0] p;
        logic d;
        int mode;
        model_reset();
        // HOLD then a full rotation
        do_reset(4'b1111, 1'b1, 3'd0);
        repeat (5) step(4'b1111, 1'b1, 3'd0);
        // Wrap from the top index back to zero, then idle
        step(4'b1001, 1'b1, 3'd0);
        step(4'b1001, 1'b1, 3'd0);
        step(4'b0000, 1'b1, 3'd0);
        // Quiescence entry and exit
        repeat (5) step(4'b0000, 1'b1, 3'd0);
        step(4'b0100, 1'b1, 3'd0);
        step(4'b0000, 1'b1, 3'd0);
        // Honoured pick, non-excited pick, out-of-range pick
        step(4'b0110, 1'b0, 3'd2);
        step(4'b0110, 1'b0, 3'd3);
        step(4'b0110, 1'b0, 3'd7);
        // Starvation under a fixed pick, sticky after det returns
        repeat (20) step(4'b0011, 1'b0, 3'd0);
        repeat (4) step(4'b0011, 1'b1, 3'd0);
        repeat (6) step(4'b0000, 1'b1, 3'd0);
        // Reset while quiet and starved
        do_reset(4'b1111, 1'b1, 3'd0);
        repeat (4) step(4'b1111, 1'b1, 3'd0);
        // Randomized blocks of differing character
        for (int blk = 0; blk < 24; blk++) begin
            mode = int'($urandom_range(0, 3));
            p = FW'($urandom_range(0, 7));
            e = N'($urandom);
            if (blk % 8 == 7) do_reset(e, 1'b1, p);
            for (int c = 0; c < 30; c++) begin
                case (mode)
                    0: begin e = N'($urandom); d = 1'b1; end
                    1: begin e = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0; d = 1'(($urandom)); p = FW'($urandom_range(0, 7)); end
                    2: begin d = 1'b0; end
                    default: begin e = N'($urandom); d = 1'(($urandom)); p = FW'($urandom_range(0, 7)); end
                endcase
                step(e, d, p);
            end
        end
        repeat (2) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
